id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, sitting directly upstream of the EX-stage operand muxes (3:1 forwarding muxes and ALUSrc 2:1 mux).
- Captures decoded operands, register specifiers and control bits each cycle.
- Inserts bubbles on flush or load-use hazard.
- Produces the 2-bit forwarding selects that drive the EX operand muxes: 00 = register file, 01 = MEM/WB, 10 = EX/MEM.

Parameters:
- DATA_W, 32, width of operand, immediate and PC+4 fields
- REG_W, 5, register specifier width
- CTRL_W, 8, width of packed control bundle

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  branch/jump taken; squash instruction entering EX
- hold_i  in  1  external freeze (e.g. multi-cycle memory); keep all registers
- id_ctrl_i  in  CTRL_W  decoded control bundle
- id_rs_i, id_rt_i, id_rd_i  in  REG_W each  specifiers
- id_rdata1_i, id_rdata2_i  in  DATA_W each  register file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_pc4_i  in  DATA_W  PC+4
- exmem_rd_i  in  REG_W  EX/MEM destination
- exmem_regwrite_i  in  1  EX/MEM writes register
- memwb_rd_i  in  REG_W  MEM/WB destination
- memwb_regwrite_i  in  1  MEM/WB writes register
- ex_ctrl_o  out  CTRL_W  registered control
- ex_rs_o, ex_rt_o, ex_rd_o  out  REG_W each  registered specifiers
- ex_rdata1_o, ex_rdata2_o, ex_imm_o, ex_pc4_o  out  DATA_W each  registered data
- fwd_a_sel_o, fwd_b_sel_o  out  2 each  forwarding mux selects for operands A and B
- stall_o  out  1  load-use hazard; PC and IF/ID must hold

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* registers are 0, which is a bubble (ctrl=0, NOP). fwd selects read 00 and stall_o reads 0 as a consequence.
- Hazard detection (combinational): stall_o = ex_ctrl_o[CTRL_MEMREAD] & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i)).
- stall_o is forced to 0 while flush_i=1 or hold_i=1.
- Register update at each rising edge, priority high to low:
  1. flush_i=1: load bubble (all fields 0).
  2. hold_i=1: retain all fields.
  3. stall_o=1: load bubble.
  4. Otherwise: load all id_* inputs.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Forwarding (combinational, from registered ex_rs_o / ex_rt_o), A path:
  - If exmem_regwrite_i & exmem_rd_i != 0 & exmem_rd_i == ex_rs_o: 10.
  - Else if memwb_regwrite_i & memwb_rd_i != 0 & memwb_rd_i == ex_rs_o: 01.
  - Else 00.
- B path is identical using ex_rt_o.
- EX/MEM always wins over MEM/WB when both match; register $0 never forwards.
- Select value 11 is never produced.
- A bubble has ex_rs_o = ex_rt_o = 0, so its selects are always 00.
- Load-use stall lasts exactly one cycle: the bubble clears MEMREAD, so stall_o drops the next cycle and the dependent instruction then receives the loaded value via select 01.
- Reset deasserted mid-operation: first clock edge after release loads normally; no stale state.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined: adds output bubble_cnt_o [31:0].
  - Increments on every edge where a bubble is loaded because of stall_o or flush_i.
  - Not incremented on hold_i.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset to 0.
- When undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - CTRL bit indices: CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_MEMTOREG=3, CTRL_ALUSRC=4, CTRL_REGDST=5, CTRL_ALUOP=7:6.
  - FWD select constants: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One natural sub-module: fwd_unit (purely combinational select logic, instantiated twice or once with both paths). Hazard logic stays inline.

Test Plan:
- Reset then release, no stimulus -> all ex_* = 0, fwd selects 00, stall_o = 0.
- add $3,$1,$2 followed by sub $4,$3,$5 -> second instruction in EX sees exmem_rd=3, regwrite=1 -> fwd_a_sel_o = 10, fwd_b_sel_o = 00.
- Same register matched in EX/MEM and MEM/WB (rd=7 both, ex_rs=7) -> fwd_a_sel_o = 10. With exmem_rd=0 and memwb_rd=0 matching rs=0 -> 00.
- lw $2,0($1) then add $4,$2,$2:
  - stall_o = 1 for one cycle and a bubble is loaded (ex_ctrl_o = 0).
  - Next cycle stall_o = 0 and the add is loaded with memwb_rd=2 -> fwd_a/b = 01.
- flush_i=1 together with a stall condition and hold_i=1 -> bubble loaded, stall_o = 0. With ID_EX_STALL_CNT_EN, bubble_cnt_o increments by exactly 1.
- hold_i=1 for 3 cycles with changing id_* inputs -> ex_* outputs unchanged. Release -> current id_* values captured on the next edge.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bundle bit positions and forwarding select codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pipe_pkg;

    // Bit positions inside the packed control bundle
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 7;

    // EX operand mux selects; 2'b11 is never produced
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand: EX/MEM beats MEM/WB, register $0 never forwards.
// Latency: purely combinational.
// Backpressure: none.
module fwd_unit
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ex_src_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic             exmem_regwrite_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    input  logic             memwb_regwrite_i,
    output logic [1:0]       fwd_sel_o
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_src_i);
    assign w_memwb_hit = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_src_i);

    // Priority select: the younger result (EX/MEM) is the architecturally correct one
    always_comb begin
        fwd_sel_o = FWD_REG;
        if (w_exmem_hit) begin
            fwd_sel_o = FWD_MEM;
        end else if (w_memwb_hit) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding selects.
// Latency: 1 cycle ID->EX; selects and stall_o are combinational from the registered stage.
// Backpressure: hold_i freezes the stage; flush_i/stall_o load a bubble. Optional ID_EX_STALL_CNT_EN adds bubble_cnt_o.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [REG_W-1:0]  id_rs_i,
    input  logic [REG_W-1:0]  id_rt_i,
    input  logic [REG_W-1:0]  id_rd_i,
    input  logic [DATA_W-1:0] id_rdata1_i,
    input  logic [DATA_W-1:0] id_rdata2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [REG_W-1:0]  exmem_rd_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_W-1:0]  memwb_rd_i,
    input  logic              memwb_regwrite_i,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [REG_W-1:0]  ex_rs_o,
    output logic [REG_W-1:0]  ex_rt_o,
    output logic [REG_W-1:0]  ex_rd_o,
    output logic [DATA_W-1:0] ex_rdata1_o,
    output logic [DATA_W-1:0] ex_rdata2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]       bubble_cnt_o
`endif
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc4;
    logic              w_load_use;
    logic              w_stall;

    // A load in EX whose target is read by the instruction in ID must wait one cycle
    assign w_load_use = r_ctrl[CTRL_MEMREAD] && (r_rt != '0) &&
                        ((r_rt == id_rs_i) || (r_rt == id_rt_i));
    // Flush already squashes and hold already freezes, so neither needs a stall
    assign w_stall    = w_load_use && !flush_i && !hold_i;

    // Stage register: flush > hold > stall bubble > normal capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl   <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_pc4    <= '0;
        end else if (flush_i || (!hold_i && w_stall)) begin
            r_ctrl   <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_pc4    <= '0;
        end else if (!hold_i) begin
            r_ctrl   <= id_ctrl_i;
            r_rs     <= id_rs_i;
            r_rt     <= id_rt_i;
            r_rd     <= id_rd_i;
            r_rdata1 <= id_rdata1_i;
            r_rdata2 <= id_rdata2_i;
            r_imm    <= id_imm_i;
            r_pc4    <= id_pc4_i;
        end
    end

    assign ex_ctrl_o   = r_ctrl;
    assign ex_rs_o     = r_rs;
    assign ex_rt_o     = r_rt;
    assign ex_rd_o     = r_rd;
    assign ex_rdata1_o = r_rdata1;
    assign ex_rdata2_o = r_rdata2;
    assign ex_imm_o    = r_imm;
    assign ex_pc4_o    = r_pc4;
    assign stall_o     = w_stall;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .ex_src_i         (r_rs),
        .exmem_rd_i       (exmem_rd_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .fwd_sel_o        (fwd_a_sel_o)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .ex_src_i         (r_rt),
        .exmem_rd_i       (exmem_rd_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .fwd_sel_o        (fwd_b_sel_o)
    );

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_bubble_cnt;

    // Count bubbles inserted by flush or load-use stall; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (flush_i || w_stall) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
